// File: rtl/pipe_seg_elastic.sv
// pipe_seg_elastic
//   Generic pipeline segment register between two CPU stages. Carries PC,
//   GPR write enable/index, HI/LO write mask and a DATA_W payload behind a
//   valid/ready handshake, with synchronous flush.
//
//   SKID=1 : main register plus one skid entry. in_ready is decoded from the
//            occupancy register only, so no combinational path from
//            out_ready reaches upstream.
//   SKID=0 : single register, in_ready = !out_valid | out_ready.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   flush                  kill held and incoming entries (next cycle empty)
//   in_valid / in_ready    upstream handshake
//   in_pc, in_regwen, in_wreg, in_whilo, in_data   upstream entry fields
//   out_valid / out_ready  downstream handshake
//   out_pc, out_regwen, out_wreg, out_whilo, out_data   registered entry;
//                          out_regwen/out_whilo forced 0 when !out_valid
module pipe_seg_elastic #(
  parameter int          DATA_W = 32,
  parameter int          WREG_W = 6,
  parameter int          HILO_W = 2,
  parameter logic [31:0] PC_RST = 32'hBFC00000,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_regwen,
  input  logic [WREG_W-1:0] in_wreg,
  input  logic [HILO_W-1:0] in_whilo,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_regwen,
  output logic [WREG_W-1:0] out_wreg,
  output logic [HILO_W-1:0] out_whilo,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    logic [31:0]       pc;
    logic              regwen;
    logic [WREG_W-1:0] wreg;
    logic [HILO_W-1:0] whilo;
    logic [DATA_W-1:0] data;
  } ent_t;

  localparam ent_t RST_ENT = '{pc: PC_RST, default: '0};

  ent_t in_ent;
  ent_t main_q;
  logic main_vld;
  logic accept;
  logic drain;

  assign in_ent = '{pc: in_pc, regwen: in_regwen, wreg: in_wreg,
                    whilo: in_whilo, data: in_data};
  assign accept = in_valid & in_ready;
  assign drain  = main_vld & out_ready;

  generate
    if (SKID) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

      occ_t state_q, state_d;
      ent_t skid_q;
      logic load_main;
      logic load_skid;
      logic from_skid;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= EMPTY;
          main_q  <= RST_ENT;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          if (load_main) main_q <= from_skid ? skid_q : in_ent;
          if (load_skid) skid_q <= in_ent;
        end
      end

      always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d   = ONE;
              load_main = 1'b1;
            end
          end
          ONE: begin
            if (accept && drain) begin
              load_main = 1'b1;
            end else if (accept) begin
              // main is stalled and must hold; park the newcomer behind it
              state_d   = FULL;
              load_skid = 1'b1;
            end else if (drain) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            // in_ready is low here, so accept cannot happen
            if (drain) begin
              state_d   = ONE;
              load_main = 1'b1;
              from_skid = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
        // flushed entries are dropped; payload registers keep stale values
        if (flush) begin
          state_d   = EMPTY;
          load_main = 1'b0;
          load_skid = 1'b0;
        end
      end

      assign main_vld = (state_q != EMPTY);
      assign in_ready = (state_q != FULL);
    end else begin : g_noskid
      logic vld_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= 1'b0;
          main_q <= RST_ENT;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (accept) begin
          vld_q  <= 1'b1;
          main_q <= in_ent;
        end else if (drain) begin
          vld_q <= 1'b0;
        end
      end

      assign main_vld = vld_q;
      assign in_ready = !vld_q | out_ready;
    end
  endgenerate

  assign out_valid  = main_vld;
  assign out_pc     = main_q.pc;
  assign out_wreg   = main_q.wreg;
  assign out_data   = main_q.data;
  // bubbles must never carry write side effects
  assign out_regwen = main_q.regwen & main_vld;
  assign out_whilo  = main_q.whilo & {HILO_W{main_vld}};

endmodule

// File: tb/tb_pipe_seg_elastic.sv
module tb_pipe_seg_elastic;

  typedef struct packed {
    logic [31:0] pc;
    logic        regwen;
    logic [5:0]  wreg;
    logic [1:0]  whilo;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_regwen, out_ready;
  logic [31:0] in_pc, in_data;
  logic [5:0]  in_wreg;
  logic [1:0]  in_whilo;

  // SKID=1 instance
  logic        rdy1, v1, rw1;
  logic [31:0] pc1, d1;
  logic [5:0]  wr1;
  logic [1:0]  wh1;
  // SKID=0 instance
  logic        rdy0, v0, rw0;
  logic [31:0] pc0, d0;
  logic [5:0]  wr0;
  logic [1:0]  wh0;

  int vec = 0;
  int errs = 0;

  // reference model: FIFO contents in acceptance order, capacity 2 or 1
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  pipe_seg_elastic #(.SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_pc(in_pc), .in_regwen(in_regwen),
    .in_wreg(in_wreg), .in_whilo(in_whilo), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_regwen(rw1),
    .out_wreg(wr1), .out_whilo(wh1), .out_data(d1)
  );

  pipe_seg_elastic #(.SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_pc(in_pc), .in_regwen(in_regwen),
    .in_wreg(in_wreg), .in_whilo(in_whilo), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_regwen(rw0),
    .out_wreg(wr0), .out_whilo(wh0), .out_data(d0)
  );

  function automatic ent_t cur_ent();
    return '{pc: in_pc, regwen: in_regwen, wreg: in_wreg, whilo: in_whilo, data: in_data};
  endfunction

  // advance one clock and update the queue model from the spec rules
  task automatic cycle();
    bit a1, a0, dr1, dr0;
    ent_t e;
    e   = cur_ent();
    a1  = in_valid && (q1.size() < 2);
    dr1 = (q1.size() > 0) && out_ready;
    a0  = in_valid && ((q0.size() == 0) || out_ready);
    dr0 = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (reset || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (dr1) void'(q1.pop_front());
      if (a1) q1.push_back(e);
      if (dr0) void'(q0.pop_front());
      if (a0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_pc = 0; in_regwen = 0;
    in_wreg = 0; in_whilo = 0; in_data = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    cycle();
    #1;
    vec++; if (v1 !== 1'b0) begin errs++; $display("FAIL reset_valid1 got %b want 0", v1); end
    vec++; if (rw1 !== 1'b0 || wh1 !== 2'b00) begin errs++; $display("FAIL reset_gate1 got %b/%b want 0/00", rw1, wh1); end
    vec++; if (pc1 !== 32'hBFC00000) begin errs++; $display("FAIL reset_pc1 got %h want bfc00000", pc1); end
    vec++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL reset_ready1 got %b want 1", rdy1); end
    vec++; if (v0 !== 1'b0 || pc0 !== 32'hBFC00000) begin errs++; $display("FAIL reset_dut0 got %b/%h want 0/bfc00000", v0, pc0); end
    vec++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL reset_ready0 got %b want 1", rdy0); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 32'h100 + 4 * i; in_regwen = 1; in_wreg = 6'd5;
      in_data = 32'hA000 + i;
      cycle();
      #1;
      vec++; if (v1 !== 1'b1 || pc1 !== 32'h100 + 4 * i) begin errs++; $display("FAIL stream_pc1[%0d] got %b/%h want 1/%h", i, v1, pc1, 32'h100 + 4 * i); end
      vec++; if (wr1 !== 6'd5 || rw1 !== 1'b1) begin errs++; $display("FAIL stream_wreg1[%0d] got %0d/%b want 5/1", i, wr1, rw1); end
      vec++; if (v0 !== 1'b1 || pc0 !== 32'h100 + 4 * i) begin errs++; $display("FAIL stream_pc0[%0d] got %b/%h want 1/%h", i, v0, pc0, 32'h100 + 4 * i); end
    end
    in_valid = 0;
    cycle();
    #1;
    vec++; if (v1 !== 1'b0 || v0 !== 1'b0) begin errs++; $display("FAIL stream_end got %b/%b want 0/0", v1, v0); end
  endtask

  task automatic test_skid_fill();
    do_reset();
    out_ready = 0; in_regwen = 0;
    in_valid = 1; in_pc = 32'h200;
    #1;
    vec++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL fill_rdy_c1 got %b want 1", rdy1); end
    cycle();
    in_pc = 32'h204;
    #1;
    vec++; if (rdy1 !== 1'b1 || pc1 !== 32'h200) begin errs++; $display("FAIL fill_c2 got %b/%h want 1/00000200", rdy1, pc1); end
    cycle();
    in_pc = 32'h208;
    #1;
    vec++; if (rdy1 !== 1'b0 || pc1 !== 32'h200 || v1 !== 1'b1) begin errs++; $display("FAIL fill_c3 got rdy %b pc %h want 0/00000200", rdy1, pc1); end
    cycle();
    #1;
    vec++; if (rdy1 !== 1'b0 || pc1 !== 32'h200) begin errs++; $display("FAIL fill_hold got rdy %b pc %h want 0/00000200", rdy1, pc1); end
    out_ready = 1;
    #1;
    vec++; if (rdy1 !== 1'b0) begin errs++; $display("FAIL fill_no_comb_path got %b want 0", rdy1); end
    cycle();
    #1;
    vec++; if (v1 !== 1'b1 || pc1 !== 32'h204 || rdy1 !== 1'b1) begin errs++; $display("FAIL drain_2nd got %b/%h/%b want 1/00000204/1", v1, pc1, rdy1); end
    cycle();
    in_valid = 0;
    #1;
    vec++; if (v1 !== 1'b1 || pc1 !== 32'h208) begin errs++; $display("FAIL drain_3rd got %b/%h want 1/00000208", v1, pc1); end
    cycle();
    #1;
    vec++; if (v1 !== 1'b0) begin errs++; $display("FAIL drain_empty got %b want 0", v1); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_regwen = 1; in_whilo = 2'b01; in_pc = 32'h400;
    cycle();
    in_pc = 32'h404;
    cycle();
    flush = 1; in_pc = 32'h300;
    #1;
    vec++; if (rdy1 !== 1'b0) begin errs++; $display("FAIL flush_pre_full got %b want 0", rdy1); end
    cycle();
    flush = 0; in_valid = 0;
    #1;
    vec++; if (v1 !== 1'b0 || rw1 !== 1'b0 || wh1 !== 2'b00) begin errs++; $display("FAIL flush_dut1 got %b/%b/%b want 0/0/00", v1, rw1, wh1); end
    vec++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL flush_ready1 got %b want 1", rdy1); end
    vec++; if (v0 !== 1'b0 || rw0 !== 1'b0) begin errs++; $display("FAIL flush_dut0 got %b/%b want 0/0", v0, rw0); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1;
      vec++; if (v1 !== 1'b0 || v0 !== 1'b0) begin errs++; $display("FAIL flush_leak[%0d] got %b/%b pc %h want 0/0", i, v1, v0, pc1); end
    end
  endtask

  task automatic test_gating();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_regwen = 1; in_whilo = 2'b11; in_pc = 32'h500; in_wreg = 6'd9;
    cycle();
    in_valid = 0;
    #1;
    vec++; if (rw1 !== 1'b1 || wh1 !== 2'b11) begin errs++; $display("FAIL gate_live got %b/%b want 1/11", rw1, wh1); end
    cycle();
    #1;
    vec++; if (v1 !== 1'b0 || rw1 !== 1'b0 || wh1 !== 2'b00) begin errs++; $display("FAIL gate_bubble1 got %b/%b/%b want 0/0/00", v1, rw1, wh1); end
    vec++; if (v0 !== 1'b0 || rw0 !== 1'b0 || wh0 !== 2'b00) begin errs++; $display("FAIL gate_bubble0 got %b/%b/%b want 0/0/00", v0, rw0, wh0); end
  endtask

  task automatic test_noskid_comb();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_pc = 32'h600;
    #1;
    vec++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL ns_empty_rdy got %b want 1", rdy0); end
    cycle();
    in_pc = 32'h604;
    #1;
    vec++; if (v0 !== 1'b1 || rdy0 !== 1'b0) begin errs++; $display("FAIL ns_stall got %b/%b want 1/0", v0, rdy0); end
    out_ready = 1;
    #1;
    vec++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL ns_comb_rdy got %b want 1", rdy0); end
    cycle();
    in_valid = 0;
    #1;
    vec++; if (v0 !== 1'b1 || pc0 !== 32'h604) begin errs++; $display("FAIL ns_pass got %b/%h want 1/00000604", v0, pc0); end
  endtask

  task automatic test_random();
    ent_t e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_regwen = 1'($urandom);
      in_wreg   = 6'($urandom);
      in_whilo  = 2'($urandom);
      in_data   = $urandom;
      #1;
      vec++; if (rdy1 !== (q1.size() < 2)) begin errs++; $display("FAIL rnd_rdy1@%0d got %b want %b", n, rdy1, q1.size() < 2); end
      vec++; if (rdy0 !== (q0.size() == 0 || out_ready)) begin errs++; $display("FAIL rnd_rdy0@%0d got %b want %b", n, rdy0, q0.size() == 0 || out_ready); end
      vec++; if (v1 !== (q1.size() > 0) || v0 !== (q0.size() > 0)) begin errs++; $display("FAIL rnd_valid@%0d got %b/%b want %b/%b", n, v1, v0, q1.size() > 0, q0.size() > 0); end
      if (q1.size() > 0) begin
        e = q1[0];
        vec++; if ({pc1, rw1, wr1, wh1, d1} !== e) begin errs++; $display("FAIL rnd_ent1@%0d got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", n, pc1, rw1, wr1, wh1, d1, e.pc, e.regwen, e.wreg, e.whilo, e.data); end
      end else begin
        vec++; if (rw1 !== 1'b0 || wh1 !== 2'b00) begin errs++; $display("FAIL rnd_gate1@%0d got %b/%b want 0/00", n, rw1, wh1); end
      end
      if (q0.size() > 0) begin
        e = q0[0];
        vec++; if ({pc0, rw0, wr0, wh0, d0} !== e) begin errs++; $display("FAIL rnd_ent0@%0d got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", n, pc0, rw0, wr0, wh0, d0, e.pc, e.regwen, e.wreg, e.whilo, e.data); end
      end else begin
        vec++; if (rw0 !== 1'b0 || wh0 !== 2'b00) begin errs++; $display("FAIL rnd_gate0@%0d got %b/%b want 0/00", n, rw0, wh0); end
      end
      cycle();
    end
    reset = 0;
    flush = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush();
    test_gating();
    test_noskid_comb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/pipe_seg_elastic.md
Name: pipe_seg_elastic

Overview:
- Parametrised successor to the fixed MEM/WB segment register.
- Generic pipeline segment between any two CPU stages, carrying PC, GPR write enable/index, HI/LO write mask and a data payload of configurable width.
- Adds a valid/ready handshake with back-pressure, synchronous flush, and an optional 2-entry skid mode, so stalls do not depend on a combinational ready path.

Parameters:
- DATA_W, 32, width of in_data/out_data payload.
- WREG_W, 6, width of destination register index.
- HILO_W, 2, width of HI/LO write mask.
- PC_RST, 32'hBFC00000, reset value of out_pc.
- SKID, 1, 1 = registered in_ready with skid entry; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  segment can accept this cycle.
- in_pc  in  32  upstream PC.
- in_regwen  in  1  GPR write enable.
- in_wreg  in  WREG_W  destination register index.
- in_whilo  in  HILO_W  HI/LO write mask.
- in_data  in  DATA_W  payload.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_pc  out  32  registered PC.
- out_regwen  out  1  registered enable, gated by valid.
- out_wreg  out  WREG_W  registered index.
- out_whilo  out  HILO_W  registered mask, gated by valid.
- out_data  out  DATA_W  registered payload.

Behaviour:
- Reset values: out_valid=0, out_regwen=0, out_wreg=0, out_whilo=0, out_pc=PC_RST, out_data=0, skid entry invalid, in_ready=1 (SKID=1) / 1 (SKID=0).
- Reset mid-transfer discards all held entries.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: 1 cycle, from accept to out_valid. Throughput: 1 entry/cycle when out_ready stays high.
- Side-effect gating: out_regwen=0 and out_whilo=0 whenever out_valid=0. No write side effects leak from bubbles.
- Hold: while out_valid & !out_ready, every out_* signal is stable.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, the main register loads.
  - On drain without accept, out_valid clears.
- SKID=1, states by occupancy:
  - EMPTY (main invalid): accept -> ONE.
  - ONE (main valid, skid invalid):
    - accept & drain -> ONE, main reloads.
    - accept & !drain -> FULL, entry goes to skid.
    - drain & !accept -> EMPTY.
  - FULL (both valid): in_ready=0. drain -> ONE, skid moves to main.
  - in_ready = !skid_valid, registered; no combinational path from out_ready.
- Ordering: entries leave in acceptance order. The skid entry never overtakes main.
- Flush (priority below reset, above all else):
  - Next cycle: out_valid=0, skid invalid, out_regwen=0, out_whilo=0.
  - Any entry accepted in the flush cycle is dropped.
  - out_pc/out_wreg/out_data keep their last values, which are don't-care.
- Simultaneous flush and drain: the drain completes downstream this cycle; the state is still emptied.

Test Plan:
- Reset, then release with in_valid=0 -> out_valid=0, out_regwen=0, out_whilo=0, out_pc=32'hBFC00000, in_ready=1.
- Stream pc=0x100,0x104,0x108 with regwen=1, wreg=6'd5 and out_ready=1 -> each appears exactly 1 cycle later, no gaps, out_wreg=5.
- SKID=1: hold out_ready=0 and offer 3 entries (pc 0x200,0x204,0x208) -> first two accepted, in_ready=0 on cycle 3, out_pc stays 0x200. Raise out_ready -> 0x200, 0x204, 0x208 drain in order.
- Assert flush while FULL with out_ready=0, together with in_valid=1 carrying pc 0x300 -> next cycle out_valid=0, out_regwen=0, in_ready=1. 0x300 never appears.
- Entry with in_regwen=1, whilo=2'b11 drains, then in_valid=0 -> out_valid=0 and out_regwen/out_whilo=0 the following cycle.
- SKID=0: out_valid=1, out_ready=0 -> in_ready=0 combinationally. Raise out_ready with in_valid=1 in the same cycle -> accept and drain together, out_valid stays 1 with the new PC.
